// File: rtl/pipe_pkg.sv
// rtl/pipe_pkg.sv - shared constants and stage record for the pipelined subtractor
// Contents:
//   PIPE_STAGES  number of register slices between input and output
//   PIPE_WIDTH   operand width the stage record is sized for
//   occ_width()  bits needed to count 0..PIPE_STAGES valid stages
//   stage_t      per-stage record: valid, sum, a, d, err
package pipe_pkg;

    localparam int PIPE_STAGES = 5;
    localparam int PIPE_WIDTH  = 8;

    function automatic int occ_width();
        return $clog2(PIPE_STAGES + 1);
    endfunction

    localparam int OCC_W = occ_width();

    // Every slice carries the full record so a stage only overrides the
    // fields it computes; the recovered operand b is d[PIPE_WIDTH-1:0].
    typedef struct packed {
        logic                  valid;
        logic [PIPE_WIDTH:0]   sum;
        logic [PIPE_WIDTH-1:0] a;
        logic [PIPE_WIDTH+1:0] d;
        logic                  err;
    } stage_t;

endpackage

// File: rtl/pipe5_sub_if.sv
// rtl/pipe5_sub_if.sv - input/output handshake bundle of pipe5_sub
// Signals:
//   in_valid/in_ready/sum_in/a_in      input beat handshake and payload
//   out_valid/out_ready/b_out/err_out  result handshake and payload
//   occupancy                          number of valid stages
// Modports: slave (the pipeline), master (the producer/consumer side)
interface pipe5_sub_if
    import pipe_pkg::*;
#(
    parameter int WIDTH = PIPE_WIDTH
) ();

    logic             in_valid;
    logic             in_ready;
    logic [WIDTH:0]   sum_in;
    logic [WIDTH-1:0] a_in;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] b_out;
    logic             err_out;
    logic [OCC_W-1:0] occupancy;

    modport slave (
        input  in_valid, sum_in, a_in, out_ready,
        output in_ready, out_valid, b_out, err_out, occupancy
    );

    modport master (
        output in_valid, sum_in, a_in, out_ready,
        input  in_ready, out_valid, b_out, err_out, occupancy
    );

endinterface

// File: rtl/pipe_stage_reg.sv
// rtl/pipe_stage_reg.sv - one enable-gated pipeline slice with async reset
// Ports:
//   clk  clock, rising edge
//   rst  asynchronous active-high reset, clears valid and payload
//   en   load d when 1, hold when 0
//   d    next stage record
//   q    registered stage record
module pipe_stage_reg
    import pipe_pkg::*;
#(
    parameter type T = stage_t
) (
    input  logic clk,
    input  logic rst,
    input  logic en,
    input  T     d,
    output T     q
);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            q <= '0;
        end else if (en) begin
            q <= d;
        end
    end

endmodule

// File: rtl/pipe5_sub.sv
// rtl/pipe5_sub.sv - five-stage pipelined b = sum - a with valid/ready flow control
// Ports:
//   clk  clock, rising edge
//   rst  asynchronous active-high reset
//   bus  pipe5_sub_if.slave: in_valid/in_ready/sum_in/a_in in,
//        out_valid/out_ready/b_out/err_out out, occupancy
// Stages: 1 capture, 2 pass, 3 subtract, 4 range check, 5 output register.
module pipe5_sub
    import pipe_pkg::*;
#(
    // stage_t is sized by PIPE_WIDTH, so WIDTH must stay equal to it
    parameter int WIDTH = PIPE_WIDTH
) (
    input  logic        clk,
    input  logic        rst,
    pipe5_sub_if.slave  bus
);

    stage_t           st_d [1:PIPE_STAGES];
    stage_t           st_q [1:PIPE_STAGES];
    logic             adv;
    logic             take_in;
    logic             take_out;
    logic [OCC_W-1:0] occ_q;

    // The whole pipe moves as one; it only stalls when the output slice
    // holds a beat the consumer is not taking. Bubbles are not collapsed.
    assign adv      = !st_q[PIPE_STAGES].valid || bus.out_ready;
    assign take_in  = bus.in_valid && adv;
    assign take_out = st_q[PIPE_STAGES].valid && bus.out_ready;

    always_comb begin
        st_d[1]       = '0;
        st_d[1].valid = bus.in_valid;
        st_d[1].sum   = bus.sum_in;
        st_d[1].a     = bus.a_in;

        st_d[2] = st_q[1];

        // Two extra bits: bit WIDTH+1 is the borrow (sum < a), bit WIDTH
        // means the difference does not fit in WIDTH bits.
        st_d[3]   = st_q[2];
        st_d[3].d = {1'b0, st_q[2].sum} - {2'b00, st_q[2].a};

        st_d[4]     = st_q[3];
        st_d[4].err = st_q[3].d[WIDTH+1] | st_q[3].d[WIDTH];

        st_d[5] = st_q[4];
    end

    for (genvar i = 1; i <= PIPE_STAGES; i++) begin : g_stage
        pipe_stage_reg #(
            .T (stage_t)
        ) u_reg (
            .clk (clk),
            .rst (rst),
            .en  (adv),
            .d   (st_d[i]),
            .q   (st_q[i])
        );
    end

    // Tracks the popcount of stage valid bits without summing them.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            occ_q <= '0;
        end else if (take_in && !take_out) begin
            occ_q <= occ_q + OCC_W'(1);
        end else if (!take_in && take_out) begin
            occ_q <= occ_q - OCC_W'(1);
        end
    end

    assign bus.in_ready  = adv;
    assign bus.out_valid = st_q[PIPE_STAGES].valid;
    assign bus.b_out     = st_q[PIPE_STAGES].d[WIDTH-1:0];
    assign bus.err_out   = st_q[PIPE_STAGES].err;
    assign bus.occupancy = occ_q;

    // Operands and the range bits are no longer needed once the result is in
    // the output slice.
    logic unused_tail;
    assign unused_tail = ^{st_q[PIPE_STAGES].sum, st_q[PIPE_STAGES].a,
                           st_q[PIPE_STAGES].d[WIDTH+1:WIDTH]};

endmodule

// File: tb/tb_pipe5_sub.sv
// tb/tb_pipe5_sub.sv - scoreboard bench for pipe5_sub
module tb_pipe5_sub;
    import pipe_pkg::*;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    pipe5_sub_if #(.WIDTH(8)) bus ();

    pipe5_sub #(.WIDTH(8)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int         total = 0;
    int         bad = 0;
    logic [8:0] exp_q [$];
    int         acc_cnt = 0;
    int         del_cnt = 0;
    int         max_occ = 0;
    bit         held_valid = 0;
    logic [8:0] held_val;
    logic [8:0] exp_item;
    bit         rand_ready = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s actual=%0h required=%0h", name, act, req);
        end
    endtask

    // Reference: plain integer difference, range checked against 0..255.
    function automatic logic [8:0] model(input logic [8:0] s, input logic [7:0] a);
        int         diff;
        logic       err;
        logic [7:0] b;
        diff = int'(s) - int'(a);
        err  = (diff < 0) || (diff > 255);
        b    = diff[7:0];
        return {err, b};
    endfunction

    // Monitor and scoreboard, sampled on the falling edge.
    always @(negedge clk) begin
        if (rst) begin
            held_valid = 0;
        end else begin
            chk("occupancy", 32'(bus.occupancy), acc_cnt - del_cnt);
            chk("in_ready", 32'(bus.in_ready), 32'(!bus.out_valid || bus.out_ready));
            if (held_valid && bus.out_valid)
                chk("output_hold", {bus.err_out, bus.b_out}, held_val);
            if (bus.out_valid && bus.out_ready) begin
                if (exp_q.size() == 0) begin
                    chk("unexpected_output", 1, 0);
                end else begin
                    exp_item = exp_q.pop_front();
                    chk("result", {bus.err_out, bus.b_out}, exp_item);
                end
                del_cnt++;
            end
            if (bus.in_valid && bus.in_ready) begin
                exp_q.push_back(model(bus.sum_in, bus.a_in));
                acc_cnt++;
            end
            held_valid = bus.out_valid && !bus.out_ready;
            held_val   = {bus.err_out, bus.b_out};
            if (int'(bus.occupancy) > max_occ) max_occ = int'(bus.occupancy);
        end
    end

    always @(posedge clk) begin
        #1;
        if (rand_ready) bus.out_ready = ($urandom_range(0, 3) != 0);
    end

    // Called #1 after a rising edge; returns #1 after the accepting edge.
    task automatic send(input logic [8:0] s, input logic [7:0] a, output int waits);
        waits = 0;
        bus.sum_in   = s;
        bus.a_in     = a;
        bus.in_valid = 1'b1;
        forever begin
            @(negedge clk);
            if (bus.in_ready) break;
            waits++;
            if (waits > 200) begin
                chk("accept_timeout", 0, 1);
                break;
            end
        end
        @(posedge clk);
        #1;
        bus.in_valid = 1'b0;
    endtask

    task automatic drain();
        int n = 0;
        while (exp_q.size() != 0 && n < 300) begin
            @(negedge clk);
            n++;
        end
        chk("drain", exp_q.size(), 0);
        @(posedge clk);
        #1;
    endtask

    // Single beat with exact latency: valid only after the 5th edge.
    task automatic single_beat(input logic [8:0] s, input logic [7:0] a);
        int w;
        send(s, a, w);
        chk("single_wait", w, 0);
        for (int i = 0; i < 5; i++) begin
            if (i > 0) @(negedge clk);
            else @(negedge clk);
            chk("single_latency", 32'(bus.out_valid), 32'(i == 4));
        end
        drain();
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1);
    end

    initial begin
        int         w;
        logic [7:0] ra, rb;
        logic [8:0] rs;

        rst           = 1'b1;
        bus.in_valid  = 1'b0;
        bus.sum_in    = '0;
        bus.a_in      = '0;
        bus.out_ready = 1'b1;
        #2;
        chk("reset_in_ready", 32'(bus.in_ready), 1);
        chk("reset_out_valid", 32'(bus.out_valid), 0);
        chk("reset_occupancy", 32'(bus.occupancy), 0);
        chk("reset_b_out", 32'(bus.b_out), 0);
        chk("reset_err_out", 32'(bus.err_out), 0);
        repeat (2) @(posedge clk);
        #3 rst = 1'b0;
        @(posedge clk);
        #1;

        single_beat(9'h0FF, 8'h0F);

        for (int i = 0; i < 10; i++) begin
            send(9'(3 * i), 8'(i), w);
            chk("stream_in_ready", w, 0);
        end
        drain();
        chk("max_occupancy", max_occ, 5);

        send(9'h000, 8'h00, w);
        send(9'h1FF, 8'hFF, w);
        send(9'h005, 8'h06, w);
        send(9'h100, 8'h01, w);
        send(9'h077, 8'h77, w);
        drain();

        bus.out_ready = 1'b0;
        for (int i = 0; i < 5; i++) send(9'(40 * i + 17), 8'(7 * i + 3), w);
        bus.sum_in   = 9'h0AB;
        bus.a_in     = 8'h2B;
        bus.in_valid = 1'b1;
        repeat (4) begin
            @(negedge clk);
            chk("bp_in_ready", 32'(bus.in_ready), 0);
            chk("bp_out_valid", 32'(bus.out_valid), 1);
            chk("bp_occupancy", 32'(bus.occupancy), 5);
        end
        @(posedge clk);
        #1;
        bus.out_ready = 1'b1;
        send(9'h0AB, 8'h2B, w);
        chk("bp_release_wait", w, 0);
        send(9'h1C0, 8'hC1, w);
        chk("bp_release_wait", w, 0);
        send(9'h003, 8'h09, w);
        chk("bp_release_wait", w, 0);
        drain();

        for (int i = 0; i < 3; i++) send(9'(i + 100), 8'(i), w);
        #1 rst = 1'b1;
        #1;
        chk("rst_out_valid", 32'(bus.out_valid), 0);
        chk("rst_occupancy", 32'(bus.occupancy), 0);
        exp_q.delete();
        acc_cnt = 0;
        del_cnt = 0;
        @(posedge clk);
        @(posedge clk);
        #3 rst = 1'b0;
        repeat (10) begin
            @(negedge clk);
            chk("no_stale_output", 32'(bus.out_valid), 0);
        end
        @(posedge clk);
        #1;
        single_beat(9'h010, 8'h04);

        rand_ready = 1;
        for (int i = 0; i < 1000; i++) begin
            ra = 8'($urandom);
            rb = 8'($urandom);
            rs = {1'b0, ra} + {1'b0, rb};
            if ($urandom_range(0, 4) == 0) begin
                @(posedge clk);
                #1;
            end
            send(rs, ra, w);
        end
        rand_ready = 0;
        @(posedge clk);
        #2 bus.out_ready = 1'b1;
        drain();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/pipe5_sub.md
Name: pipe5_sub

Overview:
- Five-stage pipelined inverse of the team's 5-stage 8-bit adder. Consumes a 9-bit sum plus one known 8-bit operand and recovers the other operand: b = sum - a.
- Adds valid/ready flow control, so it can sit downstream of the adder's output or any producer that can be stalled.
- Flags inputs where no 8-bit b exists.

Parameters:
- WIDTH, 8, operand width. sum is WIDTH+1 bits.

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  reset, asynchronous, active-high.
- in_valid  in  1  input beat present.
- in_ready  out  1  block accepts the beat this cycle.
- sum_in  in  WIDTH+1  sum to decompose.
- a_in  in  WIDTH  known operand.
- out_valid  out  1  result present at the output.
- out_ready  in  1  consumer accepts the result.
- b_out  out  WIDTH  recovered operand.
- err_out  out  1  1 when sum_in < a_in or sum_in - a_in > 2^WIDTH-1.
- occupancy  out  3  number of valid stages, 0..5.

Behaviour:
- Reset: rst is asynchronous and active-high; clk is the clock. While rst is high, all stage valid bits, stage data, b_out, err_out, out_valid and occupancy are 0. in_ready is 1 during and after reset, because out_valid is 0.
- Advance: adv = !out_valid || out_ready, and in_ready = adv. When adv is 1, every stage shifts by one on the clock edge. When adv is 0, all stages hold, including data and valid bits. No bubble collapsing.
- Accept: an input beat is accepted on an edge with in_valid && in_ready. Stage-1 valid takes the value of in_valid whenever adv is 1.
- Stage 1: register sum_in and a_in.
- Stage 2: pass through unchanged.
- Stage 3: compute d = {0,sum} - {00,a}, WIDTH+2 bits, signed interpretation.
- Stage 4: set err = d[WIDTH+1] | d[WIDTH]. Set b = d[WIDTH-1:0].
- Stage 5: output register driving b_out, err_out and out_valid.
- Latency: a beat accepted at edge k appears with out_valid=1 after edge k+4 (5 edges including acceptance) if no stall. Throughput is 1 beat per clock.
- Error result: when err is 1, b_out equals the low WIDTH bits of d, which is the two's-complement wrap. The beat still flows normally; it is not dropped.
- Output hold: while out_valid=1 and out_ready=0, b_out and err_out stay stable until the beat is taken.
- Bubbles: stage data in invalid stages is don't-care for correctness but is still registered; bubbles propagate with valid=0.
- Occupancy:
  - Updated registered each edge: +1 on accept-without-output, -1 on output-without-accept, unchanged on both or neither.
  - It always equals the popcount of the 5 stage valid bits.
  - Saturation cannot occur because accepts are gated by adv.
- Simultaneous accept and output on the same edge: occupancy unchanged, and both beats move.
- Reset mid-stream: all in-flight beats are discarded immediately (asynchronously). No output is produced for them after rst is released.
- Boundaries:
  - sum=0, a=0 gives b=0, err=0.
  - sum=2^(WIDTH+1)-1, a=2^WIDTH-1 gives b=2^WIDTH, which is out of range, so err=1 and b_out=0.
  - sum=a gives b=0, err=0.

Decomposition:
- Shared package pipe_pkg holds:
  - constant PIPE_STAGES=5;
  - the occupancy width function, clog2(PIPE_STAGES+1);
  - a stage record typedef with fields valid, sum, a, d, err.
- One natural sub-module: pipe_stage_reg, a single enable-gated register slice (valid plus payload, async reset). It is instantiated per stage, with per-stage combinational logic placed between slices in pipe5_sub.

Test Plan:
- Single beat: sum_in=9'h0FF, a_in=8'h0F, out_ready=1 -> out_valid rises exactly 5 edges after accept, b_out=8'hF0, err_out=0. occupancy goes 1..1 while in flight, then 0.
- Back-to-back stream: 10 beats on consecutive cycles with sum=i+2i, a=i for i=0..9, out_ready=1 -> b_out=2i in order, one per cycle, in_ready constantly 1, occupancy reaches 5.
- Error cases: (sum=9'h005, a=8'h06) -> err_out=1, b_out=8'hFF. (sum=9'h1FF, a=8'hFF) -> err_out=1, b_out=8'h00. (sum=9'h100, a=8'h01) -> err_out=0, b_out=8'hFF.
- Backpressure:
  - Fill 5 beats, then hold out_ready=0 for 4 cycles -> in_ready=0, b_out and err_out stable, occupancy=5, no beat lost or duplicated.
  - Release out_ready -> remaining beats are delivered in order with a simultaneous accept each cycle.
- Reset mid-operation: assert rst asynchronously between edges with 3 beats in flight -> out_valid=0 and occupancy=0 immediately. After release, no stale beats emerge, and a fresh beat (sum=9'h010, a=8'h04) yields b_out=8'h0C after 5 edges.
- Round trip: drive random a,b into the adder and feed its sum, together with a delayed a, into pipe5_sub -> b_out==b and err_out==0 for 1000 beats under random out_ready.
